mtimecmp_sched: RTL and testbench
=================================

# mtimecmp_sched

Hardware timer multiplexer that shares the single machine-timer compare register among `NUM_TIMERS` logical timers. It holds one 64-bit deadline per logical timer and continuously finds the earliest active deadline. It programs that deadline into the timer's `mtimecmp` through a DBus master port, using the glitch-free low/high/low write sequence. Expired timers are reported as one-cycle pulses. The block sits beside the machine timer on the DBus and consumes the timer's `time_rd_data`.

## Interface
- `NUM_TIMERS`, default 4: number of logical timers (≥2).
- `ID_W`, default `$clog2(NUM_TIMERS)`: timer index width.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `set_valid` in 1: load `set_cmp` into timer `set_id` and mark it active.
- `set_id` in `ID_W`: timer index for the set.
- `set_cmp` in 64: absolute deadline.
- `cancel_valid` in 1: deactivate timer `cancel_id`.
- `cancel_id` in `ID_W`: timer index for the cancel.
- `time_rd_data` in 64: current machine time.
- `dbus_gnt` in 1: DBus grant; the write is accepted in the cycle `dbus_gnt` and `dbus_wr_en` are both high.
- `dbus_wr_en` out 1: write request.
- `dbus_addr` out 2: word address. `2'b10` is `mtimecmp[31:0]`; `2'b11` is `mtimecmp[63:32]`.
- `dbus_wr_data` out 32: write data.
- `dbus_wr_strobe` out 4: always `4'hF` while `dbus_wr_en` is high, `0` otherwise.
- `active` out `NUM_TIMERS`: per-timer active mask.
- `expired` out `NUM_TIMERS`: one-cycle expiry pulses.
- `busy` out 1: FSM not in IDLE.

## Operation
- **Per-timer state:** `cmp[i]` (64 b) and `active[i]`.
- **Shadow register:** `prog_cmp` (64 b) holds the last value fully written to `mtimecmp`.
- **`dirty` flag:** set by any accepted set, cancel or expiry.
- **Set/cancel collision:** set and cancel to the same id in the same cycle means cancel wins.
- **Expiry detection:** for each `i` with `active[i] && time_rd_data >= cmp[i]` (unsigned, registered values), clear `active[i]` and pulse `expired[i]` in the next cycle.
  - A set to the same `i` in that cycle wins: the new value is loaded, the timer stays active, and no pulse is produced.
- **IDLE:** go to SCAN when `dirty`, clearing `dirty`.
- **SCAN:**
  - Walks index 0..`NUM_TIMERS-1`, one index per cycle.
  - Tracks `best` as the minimum `cmp` among active timers; ties go to the lowest index.
  - `best` starts at `64'hFFFF_FFFF_FFFF_FFFF`, so no active timers means all-ones (interrupt disabled).
  - At the end of the scan: if `best == prog_cmp`, return to IDLE. Otherwise latch `best` into `target` and go to WR_LO_MAX.
- **WR_LO_MAX:** write `32'hFFFF_FFFF` to addr `2'b10`.
- **WR_HI:** write `target[63:32]` to addr `2'b11`.
- **WR_LO:** write `target[31:0]` to addr `2'b10`. On acceptance, `prog_cmp <= target`, then go to IDLE.
- **Write handshake:** each WR state holds `dbus_wr_en`, `dbus_addr` and `dbus_wr_data` stable until `dbus_gnt`, then advances.
- **Changes during SCAN/WR:** sets, cancels and expiries are still accepted and set `dirty`. The current sequence completes unchanged, then a rescan follows from IDLE.
- **Reset:** all `cmp` = 0, `active` = 0, `prog_cmp` = 0, `dirty` = 1.
  - The first action after reset is therefore a scan, then programming all-ones. This deasserts the timer interrupt left by its reset compare of 0.

## Timing
- **Output reset values:** `dbus_wr_en` 0, `dbus_addr` 0, `dbus_wr_data` 0, `dbus_wr_strobe` 0, `active` 0, `expired` 0, `busy` 0.
- **Set to first `dbus_wr_en`:** a set in cycle t gives `dirty` at t+1, SCAN from t+2 for `NUM_TIMERS` cycles, and the first `dbus_wr_en` at t+2+`NUM_TIMERS`.
- **Write sequence:** minimum 3 cycles with continuous grant.
- **Expiry pulse:** `expired[i]` is high exactly one cycle, the cycle after the compare was true.
- **`active` updates:** one cycle after `set_valid`/`cancel_valid`.
- **Reset mid-sequence:** asynchronous return to IDLE with outputs at reset values. A partial `mtimecmp` write is repaired by the post-reset programming.

## Structure
- **Shared package** (`lexington`): the FSM state enum `sched_state_e` and the constants `MTIMECMP_LO_ADDR = 2'b10`, `MTIMECMP_HI_ADDR = 2'b11` and `MTIMECMP_DISABLE = 64'hFFFF_FFFF_FFFF_FFFF`.
- **Sub-module:** `dbus_wr_seq`, a three-step grant-handshaked writer taking `target` and a start pulse.

## Test plan
- **Reset:** release reset with no requests, `dbus_gnt=1` → writes `FFFFFFFF`@10, `FFFFFFFF`@11, `FFFFFFFF`@10; `busy` low afterwards; timer interrupt 0.
- **Earliest of two:** set timer 1 = 1000, timer 2 = 500, time 0 → `mtimecmp` programmed to 500 (lo `FFFFFFFF`, hi 0, lo 500).
- **Expiry:** with 500/1000 programmed, time reaches 500 → `expired[2]` one-cycle pulse, `active` = `4'b0010`, `mtimecmp` reprogrammed to 1000.
- **Cancel:** cancel timer 1 while timer 1 is the only active timer → `mtimecmp` = all-ones. Set and cancel of id 3 in the same cycle → `active[3]` = 0.
- **Grant stall:** hold `dbus_gnt` low for 5 cycles in WR_HI → `dbus_wr_en`, `dbus_addr` and `dbus_wr_data` stay stable; the sequence completes after the grant.
- **Mid-sequence set:** set timer 0 = 200 during WR_HI of a 500 program → the 500 sequence completes, then a rescan programs 200.

Source files
------------

// File: rtl/mtimecmp_sched_pkg.sv
// -----------------------------------------------------------------------------
// lexington: definitions shared by the mtimecmp scheduler and its DBus writer.
//   sched_state_e     - scheduler states. IDLE and SCAN belong to the top level.
//                       The three WR_* steps are sequenced by dbus_wr_seq.
//   MTIMECMP_LO_ADDR  - DBus word address of mtimecmp[31:0]
//   MTIMECMP_HI_ADDR  - DBus word address of mtimecmp[63:32]
//   MTIMECMP_DISABLE  - compare value that never fires (all ones)
// -----------------------------------------------------------------------------
package lexington;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WR_LO_MAX,
    ST_WR_HI,
    ST_WR_LO
  } sched_state_e;

  localparam logic [1:0]  MTIMECMP_LO_ADDR = 2'b10;
  localparam logic [1:0]  MTIMECMP_HI_ADDR = 2'b11;
  localparam logic [63:0] MTIMECMP_DISABLE = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mtimecmp_sched_wr_seq.sv
// -----------------------------------------------------------------------------
// dbus_wr_seq: three-step, grant-handshaked writer that loads a 64-bit value
// into mtimecmp without a transient early match. The sequence is:
// lo <= all ones, then hi <= target[63:32], then lo <= target[31:0].
// Each step holds its request stable until dbus_gnt is seen.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse that begins a sequence (accepted in IDLE)
//   target          value to program; must stay stable while the sequence runs
//   dbus_gnt        grant; a step is accepted when dbus_gnt && dbus_wr_en
//   dbus_wr_en      write request
//   dbus_addr       word address (LO/HI mtimecmp)
//   dbus_wr_data    write data
//   dbus_wr_strobe  byte strobes, all set while requesting
//   done            pulses in the cycle the final (low-word) write is accepted
//   step            current step (ST_IDLE when not writing)
// -----------------------------------------------------------------------------
module dbus_wr_seq
  import lexington::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  target,
  input  logic         dbus_gnt,
  output logic         dbus_wr_en,
  output logic [1:0]   dbus_addr,
  output logic [31:0]  dbus_wr_data,
  output logic [3:0]   dbus_wr_strobe,
  output logic         done,
  output sched_state_e step
);

  sched_state_e step_q, step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= ST_IDLE;
    end else begin
      step_q <= step_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    step_d       = step_q;
    dbus_wr_en   = 1'b0;
    dbus_addr    = 2'b00;
    dbus_wr_data = 32'h0;
    done         = 1'b0;
    unique case (step_q)
      ST_IDLE: begin
        if (start) step_d = ST_WR_LO_MAX;
      end
      ST_WR_LO_MAX: begin
        dbus_wr_en   = 1'b1;
        dbus_addr    = MTIMECMP_LO_ADDR;
        dbus_wr_data = 32'hFFFF_FFFF;
        if (dbus_gnt) step_d = ST_WR_HI;
      end
      ST_WR_HI: begin
        dbus_wr_en   = 1'b1;
        dbus_addr    = MTIMECMP_HI_ADDR;
        dbus_wr_data = target[63:32];
        if (dbus_gnt) step_d = ST_WR_LO;
      end
      ST_WR_LO: begin
        dbus_wr_en   = 1'b1;
        dbus_addr    = MTIMECMP_LO_ADDR;
        dbus_wr_data = target[31:0];
        if (dbus_gnt) begin
          done   = 1'b1;
          step_d = ST_IDLE;
        end
      end
      default: step_d = ST_IDLE;
    endcase
  end

  assign dbus_wr_strobe = dbus_wr_en ? 4'hF : 4'h0;
  assign step           = step_q;

endmodule

// File: rtl/mtimecmp_sched.sv
// -----------------------------------------------------------------------------
// mtimecmp_sched: multiplexes NUM_TIMERS logical 64-bit deadlines onto the
// single machine-timer compare register. Any set, cancel or expiry marks the
// schedule dirty. From IDLE a dirty schedule triggers a one-index-per-cycle
// scan for the earliest active deadline. If the result differs from what is
// already in mtimecmp, dbus_wr_seq programs it.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   set_valid/id/cmp    load a deadline into a timer and activate it
//   cancel_valid/id     deactivate a timer (wins over a same-id set)
//   time_rd_data        current machine time
//   dbus_gnt            DBus grant
//   dbus_wr_en/addr/wr_data/wr_strobe   DBus write master
//   active              per-timer active mask
//   expired             one-cycle expiry pulses
//   busy                scanning or writing
// -----------------------------------------------------------------------------
module mtimecmp_sched
  import lexington::*;
#(
  parameter int NUM_TIMERS = 4,
  parameter int ID_W       = $clog2(NUM_TIMERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [ID_W-1:0]       set_id,
  input  logic [63:0]           set_cmp,
  input  logic                  cancel_valid,
  input  logic [ID_W-1:0]       cancel_id,
  input  logic [63:0]           time_rd_data,
  input  logic                  dbus_gnt,
  output logic                  dbus_wr_en,
  output logic [1:0]            dbus_addr,
  output logic [31:0]           dbus_wr_data,
  output logic [3:0]            dbus_wr_strobe,
  output logic [NUM_TIMERS-1:0] active,
  output logic [NUM_TIMERS-1:0] expired,
  output logic                  busy
);

  // Per-timer state
  logic [63:0]           cmp_q [NUM_TIMERS];
  logic [63:0]           cmp_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] active_q, active_d;
  logic [NUM_TIMERS-1:0] expired_q, expired_d;

  // Scheduler state
  logic                  dirty_q, dirty_d;
  logic                  scan_q, scan_d;
  logic [ID_W-1:0]       idx_q, idx_d;
  logic [63:0]           best_q, best_d;
  logic [63:0]           target_q, target_d;
  logic [63:0]           prog_cmp_q, prog_cmp_d;

  logic                  set_win;
  logic                  any_event;
  logic                  idle;
  logic [63:0]           cand;
  logic                  wr_start;
  logic                  wr_done;
  sched_state_e          wr_step;

  // A set and cancel to the same id in one cycle: the cancel wins and the
  // set is dropped entirely.
  assign set_win = set_valid && !(cancel_valid && (cancel_id == set_id));

  // Timer bank: expiry detection, then set, then cancel, so the later
  // assignments take priority.
  always_comb begin
    cmp_d     = cmp_q;
    active_d  = active_q;
    expired_d = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (active_q[i] && (time_rd_data >= cmp_q[i])) begin
        active_d[i]  = 1'b0;
        expired_d[i] = 1'b1;
      end
    end
    if (set_win) begin
      cmp_d[set_id]     = set_cmp;
      active_d[set_id]  = 1'b1;
      expired_d[set_id] = 1'b0;
    end
    if (cancel_valid) active_d[cancel_id] = 1'b0;
  end

  assign any_event = set_valid | cancel_valid | (|expired_d);
  assign idle      = !scan_q && (wr_step == ST_IDLE);

  // Strict less-than keeps the lowest index on equal deadlines.
  assign cand = (active_q[idx_q] && (cmp_q[idx_q] < best_q)) ? cmp_q[idx_q] : best_q;

  always_comb begin
    scan_d     = scan_q;
    idx_d      = idx_q;
    best_d     = best_q;
    target_d   = target_q;
    prog_cmp_d = prog_cmp_q;
    wr_start   = 1'b0;
    // Events arriving while busy stay pending until the next return to IDLE.
    dirty_d    = dirty_q | any_event;

    if (idle && dirty_q) begin
      scan_d  = 1'b1;
      idx_d   = '0;
      best_d  = MTIMECMP_DISABLE;
      dirty_d = any_event;
    end

    if (scan_q) begin
      best_d = cand;
      idx_d  = idx_q + ID_W'(1);
      if (idx_q == ID_W'(NUM_TIMERS - 1)) begin
        scan_d = 1'b0;
        if (cand != prog_cmp_q) begin
          target_d = cand;
          wr_start = 1'b1;
        end
      end
    end

    // The shadow only follows mtimecmp once the final low word has landed.
    if (wr_done) prog_cmp_d = target_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational blocks above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the deadline array is reset explicitly because the post-reset
      // scan compares against these values. It is a flop bank, not a RAM.
      for (int i = 0; i < NUM_TIMERS; i++) cmp_q[i] <= '0;
      active_q   <= '0;
      expired_q  <= '0;
      dirty_q    <= 1'b1;
      scan_q     <= 1'b0;
      idx_q      <= '0;
      best_q     <= '0;
      target_q   <= '0;
      prog_cmp_q <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) cmp_q[i] <= cmp_d[i];
      active_q   <= active_d;
      expired_q  <= expired_d;
      dirty_q    <= dirty_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      target_q   <= target_d;
      prog_cmp_q <= prog_cmp_d;
    end
  end

  dbus_wr_seq u_wr_seq (
    .clk            (clk),
    .rst            (rst),
    .start          (wr_start),
    .target         (target_q),
    .dbus_gnt       (dbus_gnt),
    .dbus_wr_en     (dbus_wr_en),
    .dbus_addr      (dbus_addr),
    .dbus_wr_data   (dbus_wr_data),
    .dbus_wr_strobe (dbus_wr_strobe),
    .done           (wr_done),
    .step           (wr_step)
  );

  assign active  = active_q;
  assign expired = expired_q;
  assign busy    = !idle;

endmodule

// File: tb/tb_mtimecmp_sched.sv
// -----------------------------------------------------------------------------
// tb_mtimecmp_sched: directed bench for mtimecmp_sched. A timer-level model
// tracks deadlines, active mask and expiry pulses. An mtimecmp image is built
// from the accepted DBus writes and compared against the earliest active
// deadline. Hand-computed write sequences pin each scenario.
// -----------------------------------------------------------------------------
module tb_mtimecmp_sched;

  localparam int N = 4;

  logic        clk, rst;
  logic        set_valid, cancel_valid;
  logic [1:0]  set_id, cancel_id;
  logic [63:0] set_cmp, time_rd_data;
  logic        dbus_gnt;
  logic        dbus_wr_en;
  logic [1:0]  dbus_addr;
  logic [31:0] dbus_wr_data;
  logic [3:0]  dbus_wr_strobe;
  logic [N-1:0] active, expired;
  logic        busy;

  mtimecmp_sched #(.NUM_TIMERS(N), .ID_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .set_valid      (set_valid),
    .set_id         (set_id),
    .set_cmp        (set_cmp),
    .cancel_valid   (cancel_valid),
    .cancel_id      (cancel_id),
    .time_rd_data   (time_rd_data),
    .dbus_gnt       (dbus_gnt),
    .dbus_wr_en     (dbus_wr_en),
    .dbus_addr      (dbus_addr),
    .dbus_wr_data   (dbus_wr_data),
    .dbus_wr_strobe (dbus_wr_strobe),
    .active         (active),
    .expired        (expired),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0]  m_cmp [N];
  logic [N-1:0] m_active = '0;
  logic [N-1:0] m_exp    = '0;
  logic [63:0]  m_mtimecmp = '0;
  logic [33:0]  wlog[$];
  logic         stall_q = 1'b0;
  logic [1:0]   held_addr = '0;
  logic [31:0]  held_data = '0;
  int           exp2_pulses = 0;

  initial for (int i = 0; i < N; i++) m_cmp[i] = '0;

  // Next {active, expired} from the timer rules.
  function automatic logic [2*N-1:0] model_step(input logic [N-1:0] act, input logic [63:0] now,
                                                input logic sv, input logic [1:0] sid,
                                                input logic cv, input logic [1:0] cid);
    logic [N-1:0] a;
    logic [N-1:0] e;
    a = act;
    e = '0;
    for (int i = 0; i < N; i++)
      if (act[i] && now >= m_cmp[i]) begin
        a[i] = 1'b0;
        e[i] = 1'b1;
      end
    if (sv && !(cv && cid == sid)) begin
      a[sid] = 1'b1;
      e[sid] = 1'b0;
    end
    if (cv) a[cid] = 1'b0;
    return {a, e};
  endfunction

  // Earliest active deadline, or all ones when nothing is active.
  function automatic logic [63:0] model_min();
    logic [63:0] b;
    b = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < N; i++)
      if (m_active[i] && m_cmp[i] < b) b = m_cmp[i];
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active   <= '0;
      m_exp      <= '0;
      for (int i = 0; i < N; i++) m_cmp[i] <= '0;
      m_mtimecmp <= '0;
      stall_q    <= 1'b0;
    end else begin
      {m_active, m_exp} <= model_step(m_active, time_rd_data, set_valid, set_id,
                                      cancel_valid, cancel_id);
      if (set_valid && !(cancel_valid && cancel_id == set_id)) m_cmp[set_id] <= set_cmp;
      stall_q   <= dbus_wr_en && !dbus_gnt;
      held_addr <= dbus_addr;
      held_data <= dbus_wr_data;
      if (dbus_wr_en && dbus_gnt) begin
        wlog.push_back({dbus_addr, dbus_wr_data});
        if (dbus_addr == 2'b11) m_mtimecmp[63:32] <= dbus_wr_data;
        else                    m_mtimecmp[31:0]  <= dbus_wr_data;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("active", 64'(active), 64'(m_active));
      check("expired", 64'(expired), 64'(m_exp));
      check("strobe", 64'(dbus_wr_strobe), dbus_wr_en ? 64'hF : 64'h0);
      if (stall_q) begin
        check("stall_en", 64'(dbus_wr_en), 64'h1);
        check("stall_addr", 64'(dbus_addr), 64'(held_addr));
        check("stall_data", 64'(dbus_wr_data), 64'(held_data));
      end
      if (expired[2]) exp2_pulses <= exp2_pulses + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_quiet(input string name);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: busy still %0d after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic check_seq(input string name, input logic [31:0] hi, input logic [31:0] lo);
    logic [33:0] e [3];
    e[0] = {2'b10, 32'hFFFF_FFFF};
    e[1] = {2'b11, hi};
    e[2] = {2'b10, lo};
    for (int k = 0; k < 3; k++) begin
      if (wlog.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_w%0d: no write logged, required %0h", name, k, e[k]);
      end else begin
        check($sformatf("%s_w%0d", name, k), 64'(wlog.pop_front()), 64'(e[k]));
      end
    end
  endtask

  task automatic drive_set(input logic [1:0] id, input logic [63:0] v);
    @(negedge clk);
    set_valid = 1'b1;
    set_id    = id;
    set_cmp   = v;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    time t0, tw;
    int  n;
    rst = 1'b1;
    set_valid = 1'b0; set_id = '0; set_cmp = '0;
    cancel_valid = 1'b0; cancel_id = '0;
    time_rd_data = '0;
    dbus_gnt = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_wr_en", 64'(dbus_wr_en), 64'h0);
    check("rst_addr", 64'(dbus_addr), 64'h0);
    check("rst_data", 64'(dbus_wr_data), 64'h0);
    check("rst_strobe", 64'(dbus_wr_strobe), 64'h0);
    check("rst_active", 64'(active), 64'h0);
    check("rst_expired", 64'(expired), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);

    // Post-reset programming of all ones
    rst = 1'b0;
    wait_quiet("reset");
    check_seq("reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("reset_extra_writes", 64'(wlog.size()), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_irq", 64'(time_rd_data >= m_mtimecmp), 64'h0);

    // Earliest of two, plus set-to-first-write latency
    @(negedge clk);
    set_valid = 1'b1; set_id = 2'd1; set_cmp = 64'd1000;
    t0 = $time;
    @(negedge clk);
    set_id = 2'd2; set_cmp = 64'd500;
    @(negedge clk);
    set_valid = 1'b0;
    n = 0;
    while (!dbus_wr_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    tw = $time;
    check("set_to_wr_cycles", 64'((tw - t0) / 10), 64'(N + 2));
    wait_quiet("earliest");
    check_seq("earliest", 32'h0, 32'd500);
    check("earliest_extra_writes", 64'(wlog.size()), 64'h0);
    check("earliest_min", m_mtimecmp, model_min());

    // Expiry of timer 2
    @(negedge clk);
    time_rd_data = 64'd500;
    wait_quiet("expiry");
    check("expiry_pulses", 64'(exp2_pulses), 64'd1);
    check("expiry_active", 64'(active), 64'h2);
    check_seq("expiry", 32'h0, 32'd1000);
    check("expiry_min", m_mtimecmp, model_min());

    // Cancel the only active timer
    @(negedge clk);
    cancel_valid = 1'b1; cancel_id = 2'd1;
    @(negedge clk);
    cancel_valid = 1'b0;
    wait_quiet("cancel");
    check_seq("cancel", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("cancel_mtimecmp", m_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);

    // Set and cancel of id 3 in the same cycle
    @(negedge clk);
    set_valid = 1'b1; set_id = 2'd3; set_cmp = 64'd50;
    cancel_valid = 1'b1; cancel_id = 2'd3;
    @(negedge clk);
    set_valid = 1'b0; cancel_valid = 1'b0;
    @(negedge clk);
    check("setcancel_active3", 64'(active[3]), 64'h0);
    wait_quiet("setcancel");
    check("setcancel_no_writes", 64'(wlog.size()), 64'h0);

    // Grant stall in WR_HI with a set of timer 0 landing during that step
    @(negedge clk);
    time_rd_data = 64'd0;
    drive_set(2'd2, 64'd500);
    n = 0;
    while (!(dbus_wr_en && dbus_addr == 2'b11) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_reached_hi", 64'(dbus_addr), 64'h3);
    dbus_gnt = 1'b0;
    set_valid = 1'b1; set_id = 2'd0; set_cmp = 64'd200;
    @(negedge clk);
    set_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_hold_en", 64'(dbus_wr_en), 64'h1);
    check("stall_hold_addr", 64'(dbus_addr), 64'h3);
    check("stall_hold_data", 64'(dbus_wr_data), 64'h0);
    check("stall_wlog_count", 64'(wlog.size()), 64'h1);
    dbus_gnt = 1'b1;
    wait_quiet("midseq");
    check_seq("midseq_500", 32'h0, 32'd500);
    check_seq("midseq_200", 32'h0, 32'd200);
    check("midseq_mtimecmp", m_mtimecmp, 64'd200);
    check("midseq_min", m_mtimecmp, model_min());
    check("midseq_active", 64'(active), 64'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
